// File: rtl/monitor_pkg.sv
// Shared definitions for the byte-serial monitor protocol (initiator and remote side).
package monitor_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_DUMP = 8'h02;
  localparam int         HDR_LEN  = 6;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ECHO    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR_TX,
    ST_HDR_WAIT,
    ST_PAY_FETCH,
    ST_PAY_TX,
    ST_PAY_WAIT,
    ST_DUMP_RX,
    ST_DONE,
    ST_ERR
  } state_t;

  // Header byte idx of a command: cmd, raddr MSB first, len MSB first.
  function automatic logic [7:0] hdr_byte(input logic load, input logic [23:0] raddr,
                                          input logic [15:0] len, input logic [2:0] idx);
    case (idx)
      3'd0:    return load ? CMD_LOAD : CMD_DUMP;
      3'd1:    return raddr[23:16];
      3'd2:    return raddr[15:8];
      3'd3:    return raddr[7:0];
      3'd4:    return len[15:8];
      3'd5:    return len[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/monitor_tx_gate.sv
// Single-byte send gate: grants a request only while the UART is idle and
// turns the grant into a registered 1-cycle transmit pulse.
module monitor_tx_gate (
  input  logic       CLK,
  input  logic       reset,
  input  logic       req,
  input  logic [7:0] req_byte,
  output logic       ack,
  input  logic       is_transmitting,
  output logic [7:0] tx_byte,
  output logic       transmit
);

  logic [7:0] tx_byte_reg;
  logic       transmit_reg;

  // The pulse just issued also blocks a grant, since the UART busy flag lags it.
  assign ack      = req && !is_transmitting && !transmit_reg;
  assign tx_byte  = tx_byte_reg;
  assign transmit = transmit_reg;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      tx_byte_reg  <= 8'h00;
      transmit_reg <= 1'b0;
    end else begin
      transmit_reg <= ack;
      if (ack) tx_byte_reg <= req_byte;
    end
  end

endmodule

// File: rtl/monitor_master.sv
// Initiator for the byte-serial monitor protocol: stop-and-wait LOAD/DUMP over a UART.
// Optional per-byte response timeout enabled by defining MONITOR_MASTER_TIMEOUT_EN.
module monitor_master
  import monitor_pkg::*;
#(
  parameter int          LOCAL_ADDR_WIDTH = 13,
  parameter logic [23:0] TIMEOUT_CYCLES   = 24'd1200000
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_load,
  input  logic [23:0]                 cmd_raddr,
  input  logic [15:0]                 cmd_len,
  input  logic [LOCAL_ADDR_WIDTH-1:0] cmd_laddr,
  output logic [LOCAL_ADDR_WIDTH-1:0] mem_raddr,
  input  logic [7:0]                  mem_rdata,
  output logic [LOCAL_ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]                  mem_wdata,
  output logic                        mem_write,
  output logic [7:0]                  tx_byte,
  output logic                        transmit,
  input  logic                        is_transmitting,
  input  logic [7:0]                  rx_byte,
  input  logic                        received,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [1:0]                  err_code
);

  localparam int AW = LOCAL_ADDR_WIDTH;

  state_t          state_reg, state_next;
  logic            load_reg, load_next;
  logic [23:0]     raddr_reg, raddr_next;
  logic [15:0]     len_reg, len_next;
  logic [AW-1:0]   laddr_reg, laddr_next;
  logic [2:0]      idx_reg, idx_next;
  logic [7:0]      tmp_reg, tmp_next;
  logic            fetch_reg, fetch_next;
  logic [AW-1:0]   mem_raddr_reg, mem_raddr_next;
  logic [AW-1:0]   mem_waddr_reg, mem_waddr_next;
  logic [7:0]      mem_wdata_reg, mem_wdata_next;
  logic            mem_write_reg, mem_write_next;
  logic            error_reg, error_next;
  logic [1:0]      err_code_reg, err_code_next;

  logic            tx_req, tx_ack, rx_ok, timeout, waiting;
  logic [7:0]      hdr_cur, tx_data;

  assign hdr_cur = hdr_byte(load_reg, raddr_reg, len_reg, idx_reg);
  assign tx_req  = (state_reg == ST_HDR_TX) || (state_reg == ST_PAY_TX);
  assign tx_data = (state_reg == ST_PAY_TX) ? tmp_reg : hdr_cur;
  // An echo cannot legitimately arrive in the same cycle as our own transmit pulse.
  assign rx_ok   = received && !transmit;
  assign waiting = (state_reg == ST_HDR_WAIT) || (state_reg == ST_PAY_WAIT) ||
                   (state_reg == ST_DUMP_RX);

  monitor_tx_gate u_tx_gate (
    .CLK             (CLK),
    .reset           (reset),
    .req             (tx_req),
    .req_byte        (tx_data),
    .ack             (tx_ack),
    .is_transmitting (is_transmitting),
    .tx_byte         (tx_byte),
    .transmit        (transmit)
  );

`ifdef MONITOR_MASTER_TIMEOUT_EN
  logic [23:0] timer_reg, timer_next;

  always_comb begin
    timer_next = timer_reg;
    timeout    = 1'b0;
    if (tx_ack || (state_reg == ST_DUMP_RX && rx_ok)) begin
      timer_next = TIMEOUT_CYCLES;
    end else if (waiting && !rx_ok) begin
      if (timer_reg <= 24'd1) timeout = 1'b1;
      else timer_next = timer_reg - 24'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) timer_reg <= 24'd0;
    else timer_reg <= timer_next;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT_CYCLES, ERR_TIMEOUT, waiting};
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    load_next      = load_reg;
    raddr_next     = raddr_reg;
    len_next       = len_reg;
    laddr_next     = laddr_reg;
    idx_next       = idx_reg;
    tmp_next       = tmp_reg;
    fetch_next     = fetch_reg;
    mem_raddr_next = mem_raddr_reg;
    mem_waddr_next = mem_waddr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_write_next = 1'b0;
    error_next     = error_reg;
    err_code_next  = err_code_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          load_next     = cmd_load;
          raddr_next    = cmd_raddr;
          len_next      = cmd_len;
          laddr_next    = cmd_laddr;
          idx_next      = 3'd0;
          error_next    = 1'b0;
          err_code_next = ERR_NONE;
          state_next    = ST_HDR_TX;
        end
      end

      ST_HDR_TX: if (tx_ack) state_next = ST_HDR_WAIT;

      ST_HDR_WAIT: begin
        if (rx_ok) begin
          if (rx_byte != hdr_cur) begin
            error_next    = 1'b1;
            err_code_next = ERR_ECHO;
            state_next    = ST_ERR;
          end else if (idx_reg != 3'(HDR_LEN - 1)) begin
            idx_next   = idx_reg + 3'd1;
            state_next = ST_HDR_TX;
          end else if (len_reg == 16'd0) begin
            state_next = ST_DONE;
          end else if (load_reg) begin
            mem_raddr_next = laddr_reg;
            fetch_next     = 1'b0;
            state_next     = ST_PAY_FETCH;
          end else begin
            state_next = ST_DUMP_RX;
          end
        end else if (timeout) begin
          error_next    = 1'b1;
          err_code_next = ERR_TIMEOUT;
          state_next    = ST_ERR;
        end
      end

      // Address is already on mem_raddr on entry; data is valid one cycle later.
      ST_PAY_FETCH: begin
        if (!fetch_reg) begin
          fetch_next = 1'b1;
        end else begin
          tmp_next   = mem_rdata;
          fetch_next = 1'b0;
          state_next = ST_PAY_TX;
        end
      end

      ST_PAY_TX: if (tx_ack) state_next = ST_PAY_WAIT;

      ST_PAY_WAIT: begin
        if (rx_ok) begin
          if (rx_byte != tmp_reg) begin
            error_next    = 1'b1;
            err_code_next = ERR_ECHO;
            state_next    = ST_ERR;
          end else begin
            laddr_next = laddr_reg + 1'b1;
            len_next   = len_reg - 16'd1;
            if (len_reg == 16'd1) begin
              state_next = ST_DONE;
            end else begin
              mem_raddr_next = laddr_reg + 1'b1;
              state_next     = ST_PAY_FETCH;
            end
          end
        end else if (timeout) begin
          error_next    = 1'b1;
          err_code_next = ERR_TIMEOUT;
          state_next    = ST_ERR;
        end
      end

      ST_DUMP_RX: begin
        if (rx_ok) begin
          mem_waddr_next = laddr_reg;
          mem_wdata_next = rx_byte;
          mem_write_next = 1'b1;
          laddr_next     = laddr_reg + 1'b1;
          len_next       = len_reg - 16'd1;
          if (len_reg == 16'd1) state_next = ST_DONE;
        end else if (timeout) begin
          error_next    = 1'b1;
          err_code_next = ERR_TIMEOUT;
          state_next    = ST_ERR;
        end
      end

      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      load_reg      <= 1'b0;
      raddr_reg     <= 24'd0;
      len_reg       <= 16'd0;
      laddr_reg     <= '0;
      idx_reg       <= 3'd0;
      tmp_reg       <= 8'h00;
      fetch_reg     <= 1'b0;
      mem_raddr_reg <= '0;
      mem_waddr_reg <= '0;
      mem_wdata_reg <= 8'h00;
      mem_write_reg <= 1'b0;
      error_reg     <= 1'b0;
      err_code_reg  <= ERR_NONE;
    end else begin
      state_reg     <= state_next;
      load_reg      <= load_next;
      raddr_reg     <= raddr_next;
      len_reg       <= len_next;
      laddr_reg     <= laddr_next;
      idx_reg       <= idx_next;
      tmp_reg       <= tmp_next;
      fetch_reg     <= fetch_next;
      mem_raddr_reg <= mem_raddr_next;
      mem_waddr_reg <= mem_waddr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_write_reg <= mem_write_next;
      error_reg     <= error_next;
      err_code_reg  <= err_code_next;
    end
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign mem_raddr = mem_raddr_reg;
  assign mem_waddr = mem_waddr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_write = mem_write_reg;
  assign error     = error_reg;
  assign err_code  = err_code_reg;

endmodule

// File: tb/tb_monitor_master.sv
// Bench for monitor_master: local RAM, UART and remote-echo models plus a
// transfer-level reference of the expected byte stream and RAM contents.
`timescale 1ns/1ps
module tb_monitor_master;
  import monitor_pkg::*;

  localparam int LW       = 13;
  localparam int RAM_SIZE = 1 << LW;

  logic          CLK = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_load = 1'b0;
  logic [23:0]   cmd_raddr = '0;
  logic [15:0]   cmd_len = '0;
  logic [LW-1:0] cmd_laddr = '0;
  logic [LW-1:0] mem_raddr, mem_waddr;
  logic [7:0]    mem_rdata = 8'h00;
  logic [7:0]    mem_wdata;
  logic          mem_write;
  logic [7:0]    tx_byte;
  logic          transmit;
  logic          is_transmitting = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          received = 1'b0;
  logic          busy, done, error;
  logic [1:0]    err_code;

  always #5 CLK = ~CLK;

  monitor_master #(.LOCAL_ADDR_WIDTH(LW), .TIMEOUT_CYCLES(24'd100)) dut (
    .CLK(CLK), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_raddr(cmd_raddr), .cmd_len(cmd_len), .cmd_laddr(cmd_laddr),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .tx_byte(tx_byte), .transmit(transmit), .is_transmitting(is_transmitting),
    .rx_byte(rx_byte), .received(received),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Local RAM with one cycle of read latency.
  logic [7:0] ram [RAM_SIZE];
  initial begin : ram_model
    logic [LW-1:0] ra, wa;
    logic [7:0]    wd;
    logic          we;
    forever begin
      @(negedge CLK);
      ra = mem_raddr; wa = mem_waddr; wd = mem_wdata; we = mem_write;
      @(posedge CLK);
      #1;
      if (we) ram[wa] = wd;
      mem_rdata = ram[ra];
    end
  end

  // Observers
  int   cyc = 0, done_cnt = 0, wr_cnt = 0, raddr_moves = 0, tx_while_busy = 0, err_rise_cyc = 0;
  int   tx_cyc[$];
  bit   prev_err = 1'b0;
  logic [LW-1:0] last_raddr = '0;
  initial begin : monitor
    forever begin
      @(negedge CLK);
      cyc++;
      if (done) done_cnt++;
      if (mem_write) wr_cnt++;
      if (mem_raddr != last_raddr) raddr_moves++;
      last_raddr = mem_raddr;
      if (transmit) tx_cyc.push_back(cyc);
      if (transmit && is_transmitting) tx_while_busy++;
      if (error && !prev_err) err_rise_cyc = cyc;
      prev_err = error;
    end
  end

  // Remote side: UART busy time, then echo (optionally corrupted or withheld),
  // and after a DUMP header the payload bytes.
  logic [7:0] tx_log[$];
  logic [7:0] dump_q[$];
  int corrupt_idx  = -1;
  int silent_after = -1;

  task automatic send_rx(input logic [7:0] v);
    @(posedge CLK); #1;
    rx_byte = v; received = 1'b1;
    @(posedge CLK); #1;
    received = 1'b0;
  endtask

  initial begin : remote
    logic [7:0] b;
    int n;
    forever begin
      @(negedge CLK);
      if (transmit) begin
        b = tx_byte;
        tx_log.push_back(b);
        n = tx_log.size();
        @(posedge CLK); #1;
        is_transmitting = 1'b1;
        repeat ($urandom_range(2, 6)) @(posedge CLK);
        #1;
        is_transmitting = 1'b0;
        if (silent_after < 0 || n <= silent_after) begin
          repeat ($urandom_range(0, 3)) @(posedge CLK);
          send_rx((n - 1 == corrupt_idx) ? (b ^ 8'h01) : b);
          if (n == HDR_LEN && tx_log[0] == CMD_DUMP) begin
            foreach (dump_q[i]) begin
              repeat ($urandom_range(0, 3)) @(posedge CLK);
              send_rx(dump_q[i]);
            end
          end
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " transmit"}, 32'(transmit), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " error"}, 32'(error), 32'd0);
    check({tag, " err_code"}, 32'(err_code), 32'd0);
    check({tag, " tx_byte"}, 32'(tx_byte), 32'd0);
    check({tag, " mem_raddr"}, 32'(mem_raddr), 32'd0);
    check({tag, " mem_waddr"}, 32'(mem_waddr), 32'd0);
    check({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, " mem_write"}, 32'(mem_write), 32'd0);
  endtask

  task automatic issue_cmd(input logic ld, input logic [23:0] ra, input logic [15:0] ln,
                           input logic [LW-1:0] la);
    tx_log.delete(); tx_cyc.delete();
    done_cnt = 0; wr_cnt = 0; raddr_moves = 0; err_rise_cyc = 0;
    @(negedge CLK);
    check("cmd_ready before issue", 32'(cmd_ready), 32'd1);
    cmd_load = ld; cmd_raddr = ra; cmd_len = ln; cmd_laddr = la; cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    check("busy after accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit fin = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      if (cmd_ready) begin fin = 1'b1; break; end
    end
    check({tag, " returns to idle"}, 32'(fin), 32'd1);
    repeat (20) @(negedge CLK);
  endtask

  // Expected stream = 6 header bytes, plus for LOAD the len bytes of local RAM from laddr.
  task automatic run_and_verify(input string tag, input logic ld, input logic [23:0] ra,
                                input logic [15:0] ln, input logic [LW-1:0] la);
    logic [7:0] exp_q[$];
    exp_q.push_back(ld ? 8'h01 : 8'h02);
    exp_q.push_back(ra[23:16]); exp_q.push_back(ra[15:8]); exp_q.push_back(ra[7:0]);
    exp_q.push_back(ln[15:8]);  exp_q.push_back(ln[7:0]);
    if (ld) for (int i = 0; i < int'(ln); i++) exp_q.push_back(ram[LW'(int'(la) + i)]);
    issue_cmd(ld, ra, ln, la);
    wait_idle(tag, 4000);
    check({tag, " tx count"}, tx_log.size(), exp_q.size());
    foreach (exp_q[i])
      check($sformatf("%s tx[%0d]", tag, i),
            (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    check({tag, " done pulses"}, done_cnt, 32'd1);
    check({tag, " error"}, 32'(error), 32'd0);
    check({tag, " err_code"}, 32'(err_code), 32'd0);
    check({tag, " mem_write pulses"}, wr_cnt, ld ? 32'd0 : 32'(ln));
    if (!ld)
      for (int i = 0; i < int'(ln); i++)
        check($sformatf("%s ram[%0h]", tag, LW'(int'(la) + i)),
              32'(ram[LW'(int'(la) + i)]), 32'(dump_q[i]));
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n0;
    int diff;
    bit ok;
    foreach (ram[i]) ram[i] = 8'($urandom);
    repeat (4) @(negedge CLK);
    check_reset_values("reset");
    reset = 1'b1;
    repeat (3) @(negedge CLK);

    ram[13'h100] = 8'hAA; ram[13'h101] = 8'h55; ram[13'h102] = 8'h0F;
    run_and_verify("load3", 1'b1, 24'h000010, 16'd3, 13'h100);

    dump_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_and_verify("dump4", 1'b0, 24'h000100, 16'd4, 13'h0200);
    dump_q.delete();

    run_and_verify("load0", 1'b1, 24'h123456, 16'd0, 13'h0400);
    check("load0 no mem_raddr activity", raddr_moves, 32'd0);

    corrupt_idx = 3;
    issue_cmd(1'b1, 24'h000010, 16'd3, 13'h100);
    wait_idle("echo err", 2000);
    corrupt_idx = -1;
    check("echo err tx count", tx_log.size(), 32'd4);
    check("echo err error", 32'(error), 32'd1);
    check("echo err err_code", 32'(err_code), 32'd1);
    check("echo err cmd_ready", 32'(cmd_ready), 32'd1);
    check("echo err done pulses", done_cnt, 32'd0);

    silent_after = 2;
    issue_cmd(1'b1, 24'h000010, 16'd3, 13'h100);
`ifdef MONITOR_MASTER_TIMEOUT_EN
    wait_idle("timeout", 2000);
    check("timeout err_code", 32'(err_code), 32'd2);
    check("timeout error", 32'(error), 32'd1);
    check("timeout tx count", tx_log.size(), 32'd3);
    diff = (tx_cyc.size() >= 3) ? err_rise_cyc - tx_cyc[2] : -1;
    check("timeout latency in 99..101", 32'(diff >= 99 && diff <= 101), 32'd1);
`else
    repeat (400) @(negedge CLK);
    check("silent still busy", 32'(busy), 32'd1);
    check("silent no error", 32'(error), 32'd0);
    check("silent tx count", tx_log.size(), 32'd3);
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    repeat (20) @(negedge CLK);
`endif
    silent_after = -1;

    issue_cmd(1'b1, 24'h00ABCD, 16'd8, 13'h0800);
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLK);
      if (tx_log.size() >= 7) begin ok = 1'b1; break; end
    end
    check("reached payload wait", 32'(ok), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_values("mid-op reset");
    n0 = tx_log.size();
    reset = 1'b1;
    repeat (40) @(negedge CLK);
    check("no tx after reset", tx_log.size(), n0);

    dump_q = '{8'($urandom), 8'($urandom)};
    run_and_verify("wrap dump", 1'b0, 24'h000200, 16'd2, 13'h1FFF);

    for (int it = 0; it < 8; it++) begin
      logic          ld;
      logic [15:0]   ln;
      logic [LW-1:0] la;
      ld = 1'($urandom_range(0, 1));
      ln = 16'($urandom_range(0, 5));
      la = (it % 3 == 0) ? LW'(RAM_SIZE - 2) : LW'($urandom);
      dump_q.delete();
      if (!ld) for (int i = 0; i < int'(ln); i++) dump_q.push_back(8'($urandom));
      run_and_verify($sformatf("rand%0d", it), ld, 24'($urandom), ln, la);
    end
    dump_q.delete();

    check("transmit never while busy", tx_while_busy, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/monitor_master.md
Name: monitor_master

Overview:
- Initiator side of the byte-serial monitor protocol: frames LOAD (0x01) and DUMP (0x02) commands and drives them over a UART to a remote monitor.
- Supports board-to-board transfers and loopback self-test.
- LOAD streams payload from a local RAM read port; DUMP writes returned bytes into a local RAM write port.
- Stop-and-wait: every transmitted byte must be echoed before the next is sent; echoes are checked.

Parameters:
LOCAL_ADDR_WIDTH, 13, width of local RAM addresses (8 KiB)
TIMEOUT_CYCLES, 24'd1200000, per-byte response timeout in CLK cycles (100 ms at 12 MHz); used only with MONITOR_MASTER_TIMEOUT_EN

Ports:
CLK  in  1  system clock
reset  in  1  synchronous, active-low
cmd_valid  in  1  command request; accepted when cmd_ready=1
cmd_ready  out  1  high in IDLE only
cmd_load  in  1  1=LOAD (cmd byte 0x01), 0=DUMP (cmd byte 0x02)
cmd_raddr  in  24  remote address, sent MSB first as adr1..adr3
cmd_len  in  16  byte count, sent MSB first as len1,len2
cmd_laddr  in  LOCAL_ADDR_WIDTH  local RAM start address
mem_raddr  out  LOCAL_ADDR_WIDTH  local read address (RAM has 1-cycle read latency)
mem_rdata  in  8  local read data
mem_waddr  out  LOCAL_ADDR_WIDTH  local write address
mem_wdata  out  8  local write data
mem_write  out  1  write strobe, 1 cycle
tx_byte  out  8  UART byte to send
transmit  out  1  1-cycle pulse to start transmission
is_transmitting  in  1  UART busy
rx_byte  in  8  UART received byte
received  in  1  1-cycle pulse; rx_byte valid
busy  out  1  high outside IDLE
done  out  1  1-cycle pulse on successful completion
error  out  1  sticky; cleared on next accepted command
err_code  out  2  0=none, 1=echo mismatch, 2=timeout

Behaviour:
- Reset values: all strobes 0, cmd_ready 1, busy 0, error 0, err_code 0, tx_byte 0, addresses 0, state IDLE.
- Reset mid-operation aborts immediately; no further bytes are sent. The remote side is not resynchronised; host software handles that.
- Command latch:
  - On cmd_valid & cmd_ready, latch all cmd_* fields; build hdr[0..5] = {cmd, raddr[23:16], raddr[15:8], raddr[7:0], len[15:8], len[7:0]}.
  - Set idx=0, clear error/err_code, go to HDR_TX.
- HDR_TX: when is_transmitting=0, drive tx_byte=hdr[idx], pulse transmit, go to HDR_WAIT.
- HDR_WAIT: on received, compare rx_byte to hdr[idx]:
  - mismatch: go to ERR with code 1;
  - match and idx<5: idx++, go to HDR_TX;
  - match and idx==5: if len==0 go to DONE; else LOAD -> PAY_FETCH, DUMP -> DUMP_RX.
- PAY_FETCH: drive mem_raddr=laddr; next cycle capture mem_rdata into tmp; go to PAY_TX.
- PAY_TX: when is_transmitting=0, send tmp with a 1-cycle transmit pulse; go to PAY_WAIT.
- PAY_WAIT: on received:
  - mismatch vs tmp: ERR code 1;
  - match: laddr++, len--; if new len==0 go to DONE, else PAY_FETCH.
- DUMP_RX: on received, mem_waddr=laddr, mem_wdata=rx_byte, mem_write=1 (1 cycle); laddr++, len--; at 0 go to DONE. No echo check applies here.
- DONE: pulse done, go to IDLE.
- ERR: set error and err_code, go to IDLE. done is not pulsed.
- Local address wraps modulo 2^LOCAL_ADDR_WIDTH; len is 16-bit, so max 65535 bytes.
- Bytes arriving in IDLE, or in HDR_TX/PAY_TX before transmit, are ignored.
- A received pulse in the same cycle as a transmit pulse is ignored. The responder cannot echo that fast.
- cmd_valid while busy is ignored; there is no queueing.
- At most one transmit pulse per echoed byte. transmit is never asserted while is_transmitting=1.

Optional Feature:
- Macro: MONITOR_MASTER_TIMEOUT_EN.
- Defined:
  - 24-bit down-counter loaded with TIMEOUT_CYCLES on every transmit pulse and every received byte in DUMP_RX.
  - Decrements in HDR_WAIT, PAY_WAIT and DUMP_RX; on reaching 0, go to ERR with code 2.
- Undefined: no counter; the block waits indefinitely and err_code 2 never occurs.

Decomposition:
- Package monitor_pkg holds:
  - CMD_LOAD=8'h01, CMD_DUMP=8'h02, HDR_LEN=6;
  - state encoding (IDLE, HDR_TX, HDR_WAIT, PAY_FETCH, PAY_TX, PAY_WAIT, DUMP_RX, DONE, ERR);
  - err_code values.
- The remote-side monitor shares the same package.
- One sub-module: monitor_tx_gate, which arbitrates the transmit pulse against is_transmitting (single-byte send request/ack). It is reused by the remote monitor's echo path.

Test Plan:
- LOAD, raddr 0x000010, len 3, local bytes AA 55 0F, ideal echo model -> TX sequence 01 00 00 10 00 03 AA 55 0F; done pulses once; error 0.
- DUMP, raddr 0x000100, len 4, model returns header echo then 11 22 33 44 -> local RAM [laddr..+3] = 11 22 33 44; 4 mem_write pulses; done.
- LOAD with len 0 -> exactly 6 header bytes sent; done right after the 6th echo; no mem_raddr activity.
- Model corrupts the echo of the 4th header byte (returns 0x11 instead of 0x10) -> error=1, err_code=1; no further transmit; cmd_ready=1.
- With MONITOR_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=100, model silent after 2nd echo -> err_code=2 at 100±1 cycles after the 3rd transmit pulse.
- reset low during PAY_WAIT of a len-8 LOAD, then high -> all outputs at reset values; new DUMP accepted and completes normally; laddr wrap 0x1FFF->0x0000 verified with len 2.
